// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline control for the 5-stage AMA-RISCV core: boot/fill sequencing, load-use
// bubbles, redirect flushes, memory freezes and saturating stall/flush counters.
module ama_riscv_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             clear_id,
  output logic             clear_ex,
  output logic             clear_mem,
  output logic             pc_we,
  output logic             start_pc,
  output logic             imem_en,
  output logic             running,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_BOOT  = 3'd1,
    ST_FILL1 = 3'd2,
    ST_FILL2 = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             hazard_s;
  logic             stall_inc_s;
  logic             flush_inc_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard_s = ex_load & (ex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = ST_RST;
    case (state_r)
      ST_RST:   state_nxt_s = ST_BOOT;
      ST_BOOT:  state_nxt_s = ST_FILL1;
      ST_FILL1: state_nxt_s = ST_FILL2;
      ST_FILL2: state_nxt_s = ST_RUN;
      ST_RUN:   state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RST;
    endcase
  end

  // Stage control outputs; RUN resolves freeze > flush > load-use > advance
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    stall_mem   = 1'b0;
    clear_id    = 1'b0;
    clear_ex    = 1'b0;
    clear_mem   = 1'b0;
    pc_we       = 1'b0;
    start_pc    = 1'b0;
    imem_en     = 1'b0;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    case (state_r)
      ST_BOOT: begin
        start_pc  = 1'b1;
        pc_we     = 1'b1;
        imem_en   = 1'b1;
        clear_id  = 1'b1;
        clear_ex  = 1'b1;
        clear_mem = 1'b1;
      end
      ST_FILL1: begin
        pc_we     = 1'b1;
        imem_en   = 1'b1;
        clear_ex  = 1'b1;
        clear_mem = 1'b1;
      end
      ST_FILL2: begin
        pc_we     = 1'b1;
        imem_en   = 1'b1;
        clear_mem = 1'b1;
      end
      ST_RUN: begin
        if (mem_busy) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          stall_ex    = 1'b1;
          stall_mem   = 1'b1;
          stall_inc_s = 1'b1;
        end else if (ex_redirect) begin
          clear_id    = 1'b1;
          clear_ex    = 1'b1;
          pc_we       = 1'b1;
          imem_en     = 1'b1;
          flush_inc_s = 1'b1;
        end else if (hazard_s) begin
          stall_if    = 1'b1;
          stall_id    = 1'b1;
          clear_ex    = 1'b1;
          stall_inc_s = 1'b1;
        end else begin
          pc_we       = 1'b1;
          imem_en     = 1'b1;
        end
      end
      default: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        clear_id  = 1'b1;
        clear_ex  = 1'b1;
        clear_mem = 1'b1;
      end
    endcase
  end

  // Saturating event counters; cnt_clr overrides a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign running   = (state_r == ST_RUN);
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_ama_riscv_pipe_ctrl.sv
// Self-checking bench for ama_riscv_pipe_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-count based reference model.
module tb_ama_riscv_pipe_ctrl;

  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_load, ex_redirect, mem_busy, cnt_clr;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic clear_id, clear_ex, clear_mem, pc_we, start_pc, imem_en, running;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [10:0] dut_ctrl;

  int checks   = 0;
  int failures = 0;
  // reference model: rising edges seen out of reset (4 or more means RUN)
  int m_edges;
  int m_stall;
  int m_flush;
  int start_seen;

  always #5 clk = ~clk;

  ama_riscv_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_load(ex_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .cnt_clr(cnt_clr),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .clear_id(clear_id), .clear_ex(clear_ex), .clear_mem(clear_mem),
    .pc_we(pc_we), .start_pc(start_pc), .imem_en(imem_en), .running(running),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign dut_ctrl = {stall_if, stall_id, stall_ex, stall_mem, clear_id, clear_ex, clear_mem,
                     pc_we, start_pc, imem_en, running};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    bit dep;
    dep = (id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd);
    return ex_load && (ex_rd != 5'd0) && dep;
  endfunction

  // expected {stalls[4], clears[3], pc_we, start_pc, imem_en, running}
  function automatic logic [10:0] model_ctrl();
    logic [3:0] st;
    logic [2:0] cl;
    logic pw, sp, ie, rn;
    st = 4'b0000; cl = 3'b000; pw = 1'b0; sp = 1'b0; ie = 1'b0; rn = 1'b0;
    if (rst || m_edges == 0) begin
      st = 4'b1111; cl = 3'b111;
    end else if (m_edges == 1) begin
      cl = 3'b111; pw = 1'b1; sp = 1'b1; ie = 1'b1;
    end else if (m_edges == 2) begin
      cl = 3'b011; pw = 1'b1; ie = 1'b1;
    end else if (m_edges == 3) begin
      cl = 3'b001; pw = 1'b1; ie = 1'b1;
    end else begin
      rn = 1'b1;
      if (mem_busy) st = 4'b1111;
      else if (ex_redirect) begin cl = 3'b110; pw = 1'b1; ie = 1'b1; end
      else if (model_hazard()) begin st = 4'b1100; cl = 3'b010; end
      else begin pw = 1'b1; ie = 1'b1; end
    end
    return {st, cl, pw, sp, ie, rn};
  endfunction

  task automatic set_rst(input logic v);
    rst = v;
    if (v) begin
      m_edges = 0; m_stall = 0; m_flush = 0;
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_load = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
  endtask

  // check current outputs, then advance the model across one rising edge
  task automatic tick(input string tag);
    #1;
    check({tag, "_ctrl"}, 32'(dut_ctrl), 32'(model_ctrl()));
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    if (start_pc) start_seen++;
    @(posedge clk);
    if (rst) begin
      m_edges = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_edges >= 4) begin
        if (mem_busy) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        else if (ex_redirect) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        else if (model_hazard()) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      end
      if (cnt_clr) begin
        m_stall = 0; m_flush = 0;
      end
      if (m_edges < 4) m_edges++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    set_rst(1'b1);
    start_seen = 0;
    @(negedge clk);
    tick("rst");
    tick("rst");

    // boot: start_pc once, clears 111/011/001, then RUN
    set_rst(1'b0);
    for (int i = 0; i < 5; i++) tick("boot");
    check("start_pc_once", 32'(start_seen), 32'd1);
    check("running_after_boot", 32'(running), 32'd1);

    // load-use hit on rs2, then the same with rd=x0
    ex_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    tick("lu_hit");
    idle();
    tick("lu_after");
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1'b1;
    tick("lu_x0");

    // redirect wins over a load-use match
    ex_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1; ex_redirect = 1'b1;
    tick("redir_hz");
    idle();
    tick("redir_after");
    check("redir_flush_cnt", 32'(flush_cnt), 32'd1);

    // freeze with pending redirect: 3 frozen cycles, then the flush
    cnt_clr = 1'b1;
    tick("clr");
    cnt_clr = 1'b0; ex_redirect = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) tick("freeze");
    mem_busy = 1'b0;
    tick("freeze_rel");
    idle();
    tick("freeze_after");
    check("freeze_stall_cnt", 32'(stall_cnt), 32'd3);
    check("freeze_flush_cnt", 32'(flush_cnt), 32'd1);

    // saturation, then clear during a freeze
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) tick("sat");
    check("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));
    cnt_clr = 1'b1;
    tick("sat_clr");
    cnt_clr = 1'b0;
    tick("sat_cleared");
    idle();

    // async reset between edges while running
    #1 set_rst(1'b1);
    tick("async_rst");
    set_rst(1'b0);
    for (int i = 0; i < 5; i++) tick("reboot");

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_load     = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 99) < 20);
      mem_busy    = ($urandom_range(0, 99) < 25);
      cnt_clr     = ($urandom_range(0, 99) < 3);
      set_rst($urandom_range(0, 99) < 2);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ama_riscv_pipe_ctrl.md
# ama_riscv_pipe_ctrl

Pipeline control unit for the 5-stage AMA-RISCV core. It owns every stage stall/clear and PC write-enable: post-reset pipeline fill, load-use bubbles, EX-resolved redirects (branch/jump flush) and data-memory back-pressure freezes. It sits beside the decoder: the decoder produces per-instruction control, and this block decides whether each pipeline register advances, holds or is cleared. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  input  1  core clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- id_rs1  input  5  rs1 address of instruction in ID
- id_rs2  input  5  rs2 address of instruction in ID
- id_rs1_used  input  1  ID instruction reads rs1
- id_rs2_used  input  1  ID instruction reads rs2
- ex_load  input  1  instruction in EX is a load
- ex_rd  input  5  destination register of EX instruction
- ex_redirect  input  1  EX resolved a taken branch, mispredict or jump
- mem_busy  input  1  data memory not ready; whole pipeline must freeze
- cnt_clr  input  1  synchronous clear of both event counters
- stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold the corresponding pipeline register
- clear_id, clear_ex, clear_mem  output  1 each  load a bubble (NOP, all write-enables 0) into the register
- pc_we  output  1  PC register write enable
- start_pc  output  1  PC mux selects start address this cycle
- imem_en  output  1  instruction memory read enable
- running  output  1  FSM in RUN
- stall_cnt  output  CNT_W  count of load-use bubbles plus freeze cycles
- flush_cnt  output  CNT_W  count of redirect flushes

## Operation
- FSM states: RST, BOOT, FILL1, FILL2, RUN. Encoded in a state register, reset to RST.
- RST: entered asynchronously on rst=1 and held while rst=1. Outputs: clear_id=clear_ex=clear_mem=1, all stalls=1, pc_we=0, imem_en=0, start_pc=0. Leaves to BOOT on the first clock edge with rst=0.
- BOOT (1 cycle): start_pc=1, pc_we=1, imem_en=1, clear_id=clear_ex=clear_mem=1, stalls=0. Goes to FILL1.
- FILL1: clear_ex=clear_mem=1. FILL2: clear_mem=1. In both states pc_we=1, imem_en=1 and the other outputs are 0. Goes FILL1 -> FILL2 -> RUN.
- During BOOT/FILL1/FILL2, the inputs id_*, ex_*, mem_busy and ex_redirect are ignored.
- RUN: outputs are combinational on the current inputs and resolved in strict priority order.
  1. mem_busy=1: freeze. All four stalls=1, pc_we=0, imem_en=0, no clears. ex_redirect and the hazard are not acted on this cycle; they are re-evaluated when mem_busy drops.
  2. ex_redirect=1: flush. clear_id=clear_ex=1, pc_we=1 (the PC mux source is selected outside this block), imem_en=1, stalls=0.
  3. Load-use hazard: hazard = ex_load & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). Response: stall_if=stall_id=1, pc_we=0, imem_en=0, clear_ex=1.
  4. Otherwise: all stalls/clears=0, pc_we=1, imem_en=1.
- x0 never causes a hazard.
- A load-use bubble lasts exactly one cycle, because the load advances to MEM. No internal counter is needed.
- Counters:
  - stall_cnt increments by 1 in each RUN cycle with a freeze or load-use bubble.
  - flush_cnt increments by 1 in each RUN cycle with a flush.
  - Both saturate at 2^CNT_W-1.
  - Both reset to 0 on rst; cnt_clr clears both to 0 on the next edge. cnt_clr has priority over an increment in the same cycle.

## Timing
- Reset values: state=RST, stall_cnt=0, flush_cnt=0, running=0. RST outputs are as listed above and apply immediately on rst assertion, without waiting for a clock edge.
- First fetch: start_pc=1 in the first cycle after rst deasserts. The first instruction is valid in ID two cycles after that, and running=1 from the 4th cycle after deassertion.
- RUN hazard, flush and freeze outputs are same-cycle (Mealy), with zero-cycle latency from inputs. Counters update on the following edge.
- rst asserted mid-RUN or mid-freeze: RST outputs are applied immediately and the full BOOT/FILL sequence repeats.
- Simultaneous flush and load-use: flush wins. clear_id=1 removes the dependent instruction, and stall_cnt does not increment.
- Simultaneous freeze and anything else: freeze wins, and only stall_cnt increments.

## Test plan
- Reset release: rst 1->0 -> start_pc=1 for one cycle; clears follow the pattern {id,ex,mem}=111, then 011, then 001, then 000; running=1 on cycle 4; counters read 0.
- Load-use hit: RUN with ex_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> stall_if=stall_id=1, clear_ex=1, pc_we=0 for exactly one cycle; stall_cnt 0->1. Repeating with ex_rd=0 gives no stall.
- Redirect with hazard: ex_redirect=1 together with a load-use match -> clear_id=clear_ex=1, pc_we=1, no stall; flush_cnt +1, stall_cnt unchanged.
- Freeze: mem_busy=1 for 3 cycles with ex_redirect=1 -> all stalls=1, pc_we=0 throughout; the flush occurs on the first cycle with mem_busy=0; stall_cnt=3, flush_cnt=1.
- Saturation and clear: CNT_W=4 with 20 freeze cycles -> stall_cnt=15; cnt_clr pulsed during a freeze -> 0 on the next edge.
- Async reset mid-RUN: assert rst between clock edges -> all clears=1 and pc_we=0 before the next edge; the boot sequence repeats after release.
